imem_responder: RTL and testbench

Synthesizable instruction-memory responder: the memory-side end of the CPU fetch interface. It is loaded with a program over a streaming load port, then answers PC-addressed fetch requests with one-cycle latency. Fetches past the loaded program length return the end-of-program marker `32'hFFFFFFFF`. After a fixed flush window following the first marker, it asserts a sticky `done`, which replaces the host-side fetch/terminate loop in emulation.

---
 rtl/imem_responder.sv | 164 ++++++++++++++++
 tb/tb_imem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: streamed program load, one-cycle PC-addressed fetch,
// end-of-program marker for out-of-range fetches and a sticky done after a flush window.
module imem_responder #(
   parameter int unsigned DEPTH        = 256,
   parameter int unsigned FLUSH_CYCLES = 4,
   parameter logic [31:0] END_MARK     = 32'hFFFF_FFFF
) (
   input  logic                     clk,
   input  logic                     resetL,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [31:0]              ld_data,
   input  logic                     ld_last,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [31:0]              req_pc,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [31:0]              rsp_instr,
   output logic                     rsp_err,
   output logic [$clog2(DEPTH):0]   prog_len,
   output logic [31:0]              fetch_cnt,
   output logic                     done
);
   // state  | meaning
   // LOAD   | accepting program words on the load port
   // SERVE  | answering fetches, no end marker delivered yet
   // FLUSH  | still answering fetches, counting down to done
   // DONE   | sticky completion, fetch port closed
   typedef enum logic [1:0] {ST_LOAD, ST_SERVE, ST_FLUSH, ST_DONE} state_t;

   localparam int unsigned AW         = $clog2(DEPTH);
   localparam logic [31:0] FLUSH_LAST = 32'(FLUSH_CYCLES - 1);

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]     prog_len_q, prog_len_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [31:0]     rsp_instr_q, rsp_instr_d;
   logic            rsp_err_q, rsp_err_d;
   logic [31:0]     fetch_cnt_q, fetch_cnt_d;
   logic [31:0]     flush_cnt_q, flush_cnt_d;
   logic [31:0]     mem_q [DEPTH];

   logic            serving;
   logic            ld_fire;
   logic            req_fire;
   logic            rsp_fire;
   logic            end_fire;
   logic [29:0]     req_idx;

   always_comb begin
      serving   = (state_q == ST_SERVE) || (state_q == ST_FLUSH);
      ld_ready  = resetL && (state_q == ST_LOAD);
      req_ready = resetL && serving && (!rsp_valid_q || rsp_ready);
      ld_fire   = ld_valid && ld_ready;
      req_fire  = req_valid && req_ready;
      rsp_fire  = rsp_valid_q && rsp_ready;
      end_fire  = rsp_fire && (rsp_instr_q == END_MARK) && !rsp_err_q;
      req_idx   = req_pc[31:2];
   end

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      prog_len_d  = prog_len_q;
      rsp_valid_d = rsp_valid_q;
      rsp_instr_d = rsp_instr_q;
      rsp_err_d   = rsp_err_q;
      fetch_cnt_d = fetch_cnt_q;
      flush_cnt_d = flush_cnt_q;

      // One-entry output register: a new request may reload it in the same
      // cycle the previous response is taken.
      if (req_fire) begin
         rsp_valid_d = 1'b1;
         if (req_pc[1:0] != 2'b00) begin
            rsp_instr_d = END_MARK;
            rsp_err_d   = 1'b1;
         end else if (req_idx >= 30'(prog_len_q)) begin
            rsp_instr_d = END_MARK;
            rsp_err_d   = 1'b0;
         end else begin
            rsp_instr_d = mem_q[req_idx[AW-1:0]];
            rsp_err_d   = 1'b0;
         end
      end else if (rsp_fire) begin
         rsp_valid_d = 1'b0;
      end

      if (rsp_fire && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end

      case (state_q)
         ST_LOAD: begin
            if (ld_fire) begin
               wr_ptr_d = wr_ptr_q + AW'(1);
               if (ld_last || (wr_ptr_q == AW'(DEPTH - 1))) begin
                  state_d    = ST_SERVE;
                  prog_len_d = (AW + 1)'(wr_ptr_q) + (AW + 1)'(1);
               end
            end
         end
         ST_SERVE: begin
            if (end_fire) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = 32'd0;
            end
         end
         ST_FLUSH: begin
            flush_cnt_d = flush_cnt_q + 32'd1;
            if (flush_cnt_q == FLUSH_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetL) begin
         state_q     <= ST_LOAD;
         wr_ptr_q    <= '0;
         prog_len_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_instr_q <= 32'd0;
         rsp_err_q   <= 1'b0;
         fetch_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         prog_len_q  <= prog_len_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_instr_q <= rsp_instr_d;
         rsp_err_q   <= rsp_err_d;
         fetch_cnt_q <= fetch_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Storage is deliberately not reset; a reload always precedes serving.
   always_ff @(posedge clk) begin
      if (ld_fire) begin
         mem_q[wr_ptr_q] <= ld_data;
      end
   end

   always_comb begin
      rsp_valid = rsp_valid_q;
      rsp_instr = rsp_instr_q;
      rsp_err   = rsp_err_q;
      prog_len  = prog_len_q;
      fetch_cnt = fetch_cnt_q;
      done      = (state_q == ST_DONE);
   end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: directed loads and fetches push expected
// responses; a negedge monitor pops and compares on every response handshake.
module tb_imem_responder;
   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] END_W = 32'hFFFF_FFFF;

   logic                  clk;
   logic                  resetL;
   logic                  ld_valid;
   logic                  ld_ready;
   logic [31:0]           ld_data;
   logic                  ld_last;
   logic                  req_valid;
   logic                  req_ready;
   logic [31:0]           req_pc;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_instr;
   logic                  rsp_err;
   logic [8:0]            prog_len;
   logic [31:0]           fetch_cnt;
   logic                  done;

   int                    total;
   int                    passed;
   logic [32:0]           exp_q [$];
   logic [31:0]           ld_words [DEPTH];

   imem_responder #(.DEPTH(DEPTH), .FLUSH_CYCLES(4), .END_MARK(END_W)) dut (
      .clk(clk), .resetL(resetL),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
      .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
      .prog_len(prog_len), .fetch_cnt(fetch_cnt), .done(done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: a handshake seen at negedge completes on the following posedge.
   initial begin
      forever begin
         @(negedge clk);
         if (resetL && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL rsp_unexpected: got instr %h err %b with no expectation queued",
                        rsp_instr, rsp_err);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               check("rsp_instr", rsp_instr, e[31:0]);
               check("rsp_err", 32'(rsp_err), 32'(e[32]));
            end
         end
      end
   end

   task automatic do_reset();
      resetL    = 1'b0;
      ld_valid  = 1'b0;
      req_valid = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      check("rst_ld_ready", 32'(ld_ready), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_instr", rsp_instr, 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_prog_len", 32'(prog_len), 32'd0);
      check("rst_fetch_cnt", fetch_cnt, 32'd0);
      check("rst_done", 32'(done), 32'd0);
      resetL = 1'b1;
      #1;
      check("post_rst_ld_ready", 32'(ld_ready), 32'd1);
   endtask

   task automatic load_words(input int n, input logic use_last);
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_data  = ld_words[i];
         ld_last  = use_last && (i == n - 1);
         @(posedge clk);
         #1;
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] ei, input logic ee);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_pc    = pc;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         total++;
         $display("FAIL req_timeout: req_ready stayed %b for pc %h, expected 1", req_ready, pc);
      end else begin
         exp_q.push_back({ee, ei});
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   initial begin
      total     = 0;
      passed    = 0;
      resetL    = 1'b0;
      ld_valid  = 1'b0;
      ld_data   = 32'd0;
      ld_last   = 1'b0;
      req_valid = 1'b0;
      req_pc    = 32'd0;
      rsp_ready = 1'b1;
      ld_words[0] = 32'h2001_0005;
      ld_words[1] = 32'h2002_0003;
      ld_words[2] = 32'h0022_1820;

      do_reset();
      load_words(3, 1'b1);
      check("load3_prog_len", 32'(prog_len), 32'd3);
      check("load3_ld_ready", 32'(ld_ready), 32'd0);
      check("load3_req_ready", 32'(req_ready), 32'd1);

      // Back-to-back fetches at full throughput
      fetch(32'd0, 32'h2001_0005, 1'b0);
      fetch(32'd4, 32'h2002_0003, 1'b0);
      fetch(32'd8, 32'h0022_1820, 1'b0);
      @(posedge clk); #1;
      check("burst_fetch_cnt", fetch_cnt, 32'd3);

      // Misaligned PC: error marker, no flush
      fetch(32'd6, END_W, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      check("misalign_done", 32'(done), 32'd0);
      check("misalign_req_ready", 32'(req_ready), 32'd1);
      check("misalign_fetch_cnt", fetch_cnt, 32'd4);

      // Back-pressure stall with a request waiting
      fetch(32'd0, 32'h2001_0005, 1'b0);
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_pc    = 32'd4;
      repeat (3) begin
         @(posedge clk); #1;
         check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         check("stall_rsp_instr", rsp_instr, 32'h2001_0005);
         check("stall_rsp_err", 32'(rsp_err), 32'd0);
         check("stall_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      #1;
      check("release_req_ready", 32'(req_ready), 32'd1);
      exp_q.push_back({1'b0, 32'h2002_0003});
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("release_rsp_valid", 32'(rsp_valid), 32'd1);
      check("release_rsp_instr", rsp_instr, 32'h2002_0003);
      @(posedge clk); #1;
      check("stall_fetch_cnt", fetch_cnt, 32'd6);

      // End marker -> FLUSH -> done exactly 4 edges after its handshake
      fetch(32'd12, END_W, 1'b0);
      @(posedge clk); #1;
      check("flush_e0_done", 32'(done), 32'd0);
      check("flush_e0_req_ready", 32'(req_ready), 32'd1);
      repeat (3) begin
         @(posedge clk); #1;
         check("flush_done_low", 32'(done), 32'd0);
      end
      @(posedge clk); #1;
      check("flush_done_high", 32'(done), 32'd1);
      check("done_req_ready", 32'(req_ready), 32'd0);
      check("done_fetch_cnt", fetch_cnt, 32'd7);
      req_valid = 1'b1;
      req_pc    = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("done_no_rsp", 32'(rsp_valid), 32'd0);
      check("done_fetch_cnt_hold", fetch_cnt, 32'd7);
      check("done_sticky", 32'(done), 32'd1);

      // Reset while in FLUSH with a response pending; PC=1024 must not alias word 0
      do_reset();
      load_words(3, 1'b1);
      fetch(32'd1024, END_W, 1'b0);
      fetch(32'd0, 32'h2001_0005, 1'b0);
      rsp_ready = 1'b0;
      check("pending_rsp_valid", 32'(rsp_valid), 32'd1);
      resetL = 1'b0;
      @(posedge clk); #1;
      exp_q.delete();
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_rsp_instr", rsp_instr, 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_prog_len", 32'(prog_len), 32'd0);
      check("midrst_fetch_cnt", fetch_cnt, 32'd0);
      resetL = 1'b1;
      rsp_ready = 1'b1;
      #1;
      check("midrst_ld_ready", 32'(ld_ready), 32'd1);

      // Full-depth load without ld_last
      for (int i = 0; i < DEPTH; i++) ld_words[i] = 32'hA500_0000 + 32'(i);
      load_words(DEPTH, 1'b0);
      check("full_ld_ready", 32'(ld_ready), 32'd0);
      check("full_prog_len", 32'(prog_len), 32'd256);
      check("full_req_ready", 32'(req_ready), 32'd1);
      fetch(32'd1020, 32'hA500_00FF, 1'b0);
      fetch(32'd512, 32'hA500_0080, 1'b0);
      fetch(32'd1024, END_W, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      check("full_done", 32'(done), 32'd1);
      check("full_fetch_cnt", fetch_cnt, 32'd3);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
      $fatal(1, "watchdog");
   end

endmodule
